// File: rtl/div_m_pkg.sv
// div_m_pkg: shared widths and constants for the divide-by-N generator
package div_m_pkg;
   localparam int N_W     = 6;
   localparam int N_MIN   = 2;
   localparam int N_RST   = 4;
   localparam int N_CLAMP = N_MIN;
endpackage

// File: rtl/div_m_gen_if.sv
// div_m_gen_if: enable, config handshake and divider outputs of div_m_gen
interface div_m_gen_if #(parameter int N_W = div_m_pkg::N_W);
   logic           en;
   logic [N_W-1:0] n_cfg;
   logic           cfg_valid;
   logic           cfg_ready;
   logic           m_cfg;
   logic           clk2;
   logic           clk4;
   logic           div_m;
   logic           m_mode;
   logic [N_W-1:0] cnt;
   modport master (
      output en, n_cfg, cfg_valid, m_cfg,
      input  cfg_ready, clk2, clk4, div_m, m_mode, cnt
   );
   modport slave (
      input  en, n_cfg, cfg_valid, m_cfg,
      output cfg_ready, clk2, clk4, div_m, m_mode, cnt
   );
endinterface

// File: rtl/div_m_phase.sv
// div_m_phase: 2-bit phase counter giving divide-by-2 and divide-by-4 outputs
module div_m_phase (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   output logic o_clk2,
   output logic o_clk4
);
   logic [1:0] r_ph;
   // advance the phase on each enabled cycle, wrapping 3->0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_ph <= '0;
      else if (i_en) r_ph <= r_ph + 2'd1;
   end
   assign o_clk2 = r_ph[0];
   assign o_clk4 = r_ph[1];
endmodule

// File: rtl/div_m_gen.sv
// div_m_gen: divide-by-N frame pulse with frame-aligned N/M reconfiguration
module div_m_gen #(
   parameter int N_W   = div_m_pkg::N_W,
   parameter int N_RST = div_m_pkg::N_RST
) (
   input logic        clk,
   input logic        rst,
   div_m_gen_if.slave bus
);
   import div_m_pkg::*;
   logic [N_W-1:0] r_cnt;
   logic [N_W-1:0] r_n_act;
   logic [N_W-1:0] r_n_sh;
   logic           r_m_sh;
   logic           r_m_mode;
   logic           r_pend;
   logic           r_div_m;
   logic           w_wrap;
   logic           w_acc;
   logic [N_W-1:0] w_n_clamp;
   logic           w_clk2;
   logic           w_clk4;
   // frame boundary, handshake acceptance and ratio clamp
   always_comb begin
      w_wrap    = bus.en && (r_cnt == r_n_act - N_W'(1));
      w_acc     = bus.cfg_valid && !r_pend;
      w_n_clamp = (bus.n_cfg < N_W'(N_CLAMP)) ? N_W'(N_CLAMP) : bus.n_cfg;
   end
   // frame counter, pulse, and shadow-to-active transfer at the boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_n_act  <= N_W'(N_RST);
         r_n_sh   <= '0;
         r_m_sh   <= 1'b0;
         r_m_mode <= 1'b0;
         r_pend   <= 1'b0;
         r_div_m  <= 1'b0;
      end else begin
         r_div_m <= w_wrap;
         if (bus.en) r_cnt <= w_wrap ? '0 : r_cnt + N_W'(1);
         if (w_wrap && r_pend) begin
            r_n_act  <= r_n_sh;
            r_m_mode <= r_m_sh;
            r_pend   <= 1'b0;
         end else if (w_wrap && w_acc) begin
            r_n_act  <= w_n_clamp;
            r_m_mode <= bus.m_cfg;
         end else if (w_acc) begin
            r_n_sh <= w_n_clamp;
            r_m_sh <= bus.m_cfg;
            r_pend <= 1'b1;
         end
      end
   end
   div_m_phase u_phase (
      .clk    (clk),
      .rst    (rst),
      .i_en   (bus.en),
      .o_clk2 (w_clk2),
      .o_clk4 (w_clk4)
   );
   assign bus.cfg_ready = !r_pend;
   assign bus.div_m     = r_div_m;
   assign bus.m_mode    = r_m_mode;
   assign bus.cnt       = r_cnt;
   assign bus.clk2      = w_clk2;
   assign bus.clk4      = w_clk4;
endmodule

// File: tb/tb_div_m_gen.sv
// tb_div_m_gen: directed checks of frame length, reconfiguration, freeze and reset
module tb_div_m_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   int ph_e = 0;
   div_m_gen_if bus ();
   div_m_gen dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      if (bus.en && !rst) ph_e++;
      #1;
   endtask
   task automatic chk_st(input string tag, input int c, input logic d, input logic m);
      chk({tag, ".cnt"}, 32'(bus.cnt), c);
      chk({tag, ".div_m"}, 32'(bus.div_m), 32'(d));
      chk({tag, ".m_mode"}, 32'(bus.m_mode), 32'(m));
      chk({tag, ".clk2"}, 32'(bus.clk2), 32'(ph_e[0]));
      chk({tag, ".clk4"}, 32'(bus.clk4), 32'(ph_e[1]));
   endtask
   task automatic req(input logic [5:0] n, input logic m);
      bus.cfg_valid = 1'b1;
      bus.n_cfg     = n;
      bus.m_cfg     = m;
      step();
      bus.cfg_valid = 1'b0;
   endtask
   initial begin
      bus.en = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.n_cfg = '0;
      bus.m_cfg = 1'b0;
      repeat (2) step();
      chk_st("rst", 0, 0, 0);
      chk("rst.ready", 32'(bus.cfg_ready), 1);
      rst = 1'b0;
      bus.en = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk_st("base", k % 4, k % 4 == 0, 0);
      end
      step();
      chk_st("n7a", 1, 0, 0);
      req(7, 1);
      chk_st("n7b", 2, 0, 0);
      chk("n7b.ready", 32'(bus.cfg_ready), 0);
      step();
      chk_st("n7c", 3, 0, 0);
      chk("n7c.ready", 32'(bus.cfg_ready), 0);
      step();
      chk_st("n7wrap", 0, 1, 1);
      chk("n7wrap.ready", 32'(bus.cfg_ready), 1);
      for (int k = 1; k <= 6; k++) begin
         step();
         chk_st("n7f", k, 0, 1);
      end
      step();
      chk_st("n7end", 0, 1, 1);
      repeat (6) step();
      chk_st("n7pre", 6, 0, 1);
      req(3, 0);
      chk_st("n3wrap", 0, 1, 0);
      chk("n3wrap.ready", 32'(bus.cfg_ready), 1);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk_st("n3f", k % 3, k == 3, 0);
         chk("n3f.ready", 32'(bus.cfg_ready), 1);
      end
      req(0, 0);
      chk_st("n0a", 1, 0, 0);
      step();
      step();
      chk_st("n0w", 0, 1, 0);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk_st("n0f", k % 2, k % 2 == 0, 0);
      end
      req(1, 1);
      chk_st("n1a", 1, 0, 0);
      step();
      chk_st("n1w", 0, 1, 1);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk_st("n1f", k % 2, k % 2 == 0, 1);
      end
      req(5, 0);
      step();
      chk_st("n5w", 0, 1, 0);
      step();
      step();
      chk_st("pre", 2, 0, 0);
      bus.en = 1'b0;
      req(6, 1);
      chk_st("frz", 2, 0, 0);
      chk("frz.ready", 32'(bus.cfg_ready), 0);
      repeat (4) begin
         step();
         chk_st("frz", 2, 0, 0);
      end
      bus.en = 1'b1;
      step();
      chk_st("res", 3, 0, 0);
      step();
      step();
      chk_st("n6w", 0, 1, 1);
      chk("n6w.ready", 32'(bus.cfg_ready), 1);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk_st("n6f", k, 0, 1);
      end
      bus.en = 1'b0;
      req(9, 0);
      chk_st("hold", 5, 0, 1);
      chk("hold.ready", 32'(bus.cfg_ready), 0);
      #2;
      rst = 1'b1;
      ph_e = 0;
      #1;
      chk_st("arst", 0, 0, 0);
      chk("arst.ready", 32'(bus.cfg_ready), 1);
      step();
      rst = 1'b0;
      bus.en = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk_st("post", k % 4, k % 4 == 0, 0);
         chk("post.ready", 32'(bus.cfg_ready), 1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/div_m_gen.md
DIV_M_GEN -- requirements
Module: div_m_gen

Interface
REQ-001 SHALL provide parameter N_W, default 6: width of divide-ratio and count fields.
REQ-002 SHALL provide parameter N_RST, default 4: active divide ratio loaded at reset.
REQ-003 clk  input  1  single block clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count enable; low freezes all counters.
REQ-006 n_cfg  input  N_W  requested divide ratio N.
REQ-007 cfg_valid  input  1  n_cfg/m_cfg request qualifier.
REQ-008 cfg_ready  output  1  block can accept a request.
REQ-009 m_cfg  input  1  requested mode bit M, travels with n_cfg.
REQ-010 clk2  output  1  divide-by-2 phase of enabled clk cycles.
REQ-011 clk4  output  1  divide-by-4 phase of enabled clk cycles.
REQ-012 div_m  output  1  one-cycle pulse once per N enabled cycles.
REQ-013 m_mode  output  1  active mode bit M for the downstream hold-control stage.
REQ-014 cnt  output  N_W  current frame count, 0..N_act-1.

Function
REQ-015 Accept on rising edge with cfg_valid=1 and cfg_ready=1; capture n_cfg, m_cfg into shadow; set pending.
REQ-016 cfg_ready = not pending; combinational from the registered pending flag only.
REQ-017 Clamp captured n_cfg below 2 to 2; no other range check.
REQ-018 Enabled cycle: cnt increments; at cnt==N_act-1, cnt wraps to 0 next cycle ("wrap cycle").
REQ-019 div_m registered: high in exactly the cycle after a wrap cycle, low otherwise; latency 1 cycle from cnt==N_act-1.
REQ-020 Wrap cycle with pending: shadow to N_act and m_mode at the same edge; pending clears; cfg_ready high next cycle.
REQ-021 Handshake coinciding with a wrap cycle, no pending: new values take effect at that boundary; pending stays 0.
REQ-022 Handshake with no wrap: values wait in shadow; current frame completes at old N_act.
REQ-023 clk2/clk4: 2-bit phase counter ph incremented each enabled cycle; clk2=ph[0], clk4=ph[1], both registered, both wrap 3->0.
REQ-024 en=0: cnt, ph, clk2, clk4 hold; div_m forced 0 next cycle; handshake still accepted, applied only at an enabled wrap.
REQ-025 m_mode changes only at frame boundaries (REQ-020/021), never mid-frame.
REQ-026 If N_act is reduced, wrap occurs only at the boundary, so cnt never exceeds N_act-1.

Reset
REQ-027 rst=1 asynchronously forces cnt=0, ph=0, clk2=0, clk4=0, div_m=0, N_act=N_RST, m_mode=0, pending=0 (cfg_ready=1).
REQ-028 Reset mid-frame or with pending discards the shadow; counting restarts from cnt=0 on the first enabled edge after rst deasserts.

Structure
REQ-029 Package div_m_pkg SHALL hold N_W, N_MIN=2, N_RST and the clamp constant; no typedefs beyond these widths.
REQ-030 One sub-module, div_m_phase, SHALL implement the 2-bit clk2/clk4 phase counter with en and rst.
REQ-031 Estimated 150-250 RTL lines; no combinational path from cfg_valid to cfg_ready.

Verification
REQ-032 Reset release, en=1, no config -> div_m pulses every 4 cycles; clk2 period 2, clk4 period 4; m_mode=0.
REQ-033 Mid-frame write n_cfg=7, m_cfg=1 at cnt=1 -> cfg_ready low until the wrap; next frame is 7 cycles; m_mode rises at the boundary.
REQ-034 Write at the wrap cycle with n_cfg=3 -> the following frame is 3 cycles; cfg_ready never drops.
REQ-035 n_cfg=0 and n_cfg=1 -> both clamp to 2; div_m pulses every 2 enabled cycles.
REQ-036 en low for 5 cycles at cnt=2 -> cnt, clk2, clk4 frozen; div_m 0; resume continues from cnt=2.
REQ-037 rst asserted with pending=1 at cnt=5 -> all outputs at reset values immediately; N_act=4; shadow lost.
